// File: rtl/zx_mem_pkg.sv
// Shared types and default widths for the ZX RAM arbiter.
// Used by zx_mem_arbiter and zx_arb_prio.
package zx_mem_pkg;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_VID) ? OWN_CPU : OWN_VID;
    endfunction

endpackage

// File: rtl/zx_arb_prio.sv
// Combinational winner select between the CPU and video ports.
// On contention the port given by 'prefer' wins.
module zx_arb_prio
    import zx_mem_pkg::*;
(
    input  logic   cpu_req,
    input  logic   vid_req,
    input  owner_t prefer,
    output logic   grant,
    output owner_t winner
);

    always_comb begin
        grant  = cpu_req | vid_req;
        winner = OWN_CPU;
        if (cpu_req && vid_req) begin
            winner = prefer;
        end else if (vid_req) begin
            winner = OWN_VID;
        end
    end

endmodule

// File: rtl/zx_mem_arbiter.sv
// Single-port RAM arbiter/sequencer for the Z80 CPU and video fetch ports.
// Define ZX_ARB_FAIR_EN for alternating priority on contention; default is strict video priority.
module zx_mem_arbiter
    import zx_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_valid,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid,

    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_t        state_reg,     state_next;
    owner_t        owner_reg,     owner_next;
    logic          op_we_reg,     op_we_next;
    logic          cpu_ack_reg,   cpu_ack_next;
    logic          vid_ack_reg,   vid_ack_next;
    logic          cpu_valid_reg, cpu_valid_next;
    logic          vid_valid_reg, vid_valid_next;
    logic [DW-1:0] cpu_dout_reg,  cpu_dout_next;
    logic [DW-1:0] vid_dout_reg,  vid_dout_next;
    logic          mem_ce_reg,    mem_ce_next;
    logic          mem_we_reg,    mem_we_next;
    logic [AW-1:0] mem_a_reg,     mem_a_next;
    logic [DW-1:0] mem_din_reg,   mem_din_next;

    owner_t prefer;
    logic   grant_any;
    owner_t winner;
    logic   take;

`ifdef ZX_ARB_FAIR_EN
    // Preferred port on the next contended grant; only contended grants move it.
    owner_t ptr_reg, ptr_next;

    assign prefer = ptr_reg;

    always_comb begin
        ptr_next = ptr_reg;
        if (take && cpu_req && vid_req) begin
            ptr_next = other_owner(winner);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= OWN_VID;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    assign prefer = OWN_VID;
`endif

    zx_arb_prio u_prio (
        .cpu_req (cpu_req),
        .vid_req (vid_req),
        .prefer  (prefer),
        .grant   (grant_any),
        .winner  (winner)
    );

    // A new grant may only be issued from IDLE or RESP; ACCESS is the RAM cycle.
    assign take = grant_any && (state_reg != ACCESS);

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        op_we_next     = op_we_reg;
        cpu_ack_next   = 1'b0;
        vid_ack_next   = 1'b0;
        cpu_valid_next = 1'b0;
        vid_valid_next = 1'b0;
        cpu_dout_next  = cpu_dout_reg;
        vid_dout_next  = vid_dout_reg;
        mem_ce_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_a_next     = mem_a_reg;
        mem_din_next   = mem_din_reg;

        case (state_reg)
            IDLE:   state_next = IDLE;
            ACCESS: state_next = RESP;
            RESP: begin
                state_next = IDLE;
                if (!op_we_reg) begin
                    if (owner_reg == OWN_VID) begin
                        vid_dout_next  = mem_dout;
                        vid_valid_next = 1'b1;
                    end else begin
                        cpu_dout_next  = mem_dout;
                        cpu_valid_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (take) begin
            state_next  = ACCESS;
            owner_next  = winner;
            mem_ce_next = 1'b1;
            if (winner == OWN_VID) begin
                vid_ack_next = 1'b1;
                mem_a_next   = vid_addr;
                op_we_next   = 1'b0;
            end else begin
                cpu_ack_next = 1'b1;
                mem_a_next   = cpu_addr;
                mem_din_next = cpu_din;
                mem_we_next  = cpu_we;
                op_we_next   = cpu_we;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_CPU;
            op_we_reg     <= 1'b0;
            cpu_ack_reg   <= 1'b0;
            vid_ack_reg   <= 1'b0;
            cpu_valid_reg <= 1'b0;
            vid_valid_reg <= 1'b0;
            cpu_dout_reg  <= '0;
            vid_dout_reg  <= '0;
            mem_ce_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_a_reg     <= '0;
            mem_din_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            op_we_reg     <= op_we_next;
            cpu_ack_reg   <= cpu_ack_next;
            vid_ack_reg   <= vid_ack_next;
            cpu_valid_reg <= cpu_valid_next;
            vid_valid_reg <= vid_valid_next;
            cpu_dout_reg  <= cpu_dout_next;
            vid_dout_reg  <= vid_dout_next;
            mem_ce_reg    <= mem_ce_next;
            mem_we_reg    <= mem_we_next;
            mem_a_reg     <= mem_a_next;
            mem_din_reg   <= mem_din_next;
        end
    end

    assign cpu_ack   = cpu_ack_reg;
    assign vid_ack   = vid_ack_reg;
    assign cpu_valid = cpu_valid_reg;
    assign vid_valid = vid_valid_reg;
    assign cpu_dout  = cpu_dout_reg;
    assign vid_dout  = vid_dout_reg;
    assign mem_ce    = mem_ce_reg;
    assign mem_we    = mem_we_reg;
    assign mem_a     = mem_a_reg;
    assign mem_din   = mem_din_reg;

endmodule

// File: doc/zx_mem_arbiter.md
# zx_mem_arbiter

Single-port RAM arbiter and sequencer sharing one synchronous RAM instance (1-cycle registered read, write on ce&we) between the Z80 CPU port and the video fetch port. Sits between the CPU bus decode / video address generator and the RAM macro. Video is latency-critical and wins contention by default. Each granted access runs a fixed two-cycle sequence with a request/acknowledge handshake and a one-cycle read-data valid strobe.

## Interface
- AW, 14, RAM address width
- DW, 8, data width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_ack  out  1  one-cycle pulse: CPU request granted
- cpu_dout  out  DW  CPU read data, held until next CPU read completes
- cpu_valid  out  1  one-cycle pulse: cpu_dout updated
- vid_req  in  1  video read request, held until vid_ack
- vid_addr  in  AW  video address
- vid_ack  out  1  one-cycle pulse: video request granted
- vid_dout  out  DW  video read data, held
- vid_valid  out  1  one-cycle pulse: vid_dout updated
- mem_ce, mem_we  out  1  RAM enable / write enable
- mem_a  out  AW  RAM address
- mem_din  out  DW  RAM write data
- mem_dout  in  DW  RAM registered read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req, register winner's address/we/data onto mem_*, mem_ce=1, pulse winner's ack, latch owner and op, go ACCESS; else stay.
- ACCESS: RAM performs access on this edge; mem_ce<=0, mem_we<=0; go RESP.
- RESP: mem_dout valid. If op was read, capture into owner's dout and pulse owner's valid; writes give no valid. Simultaneously arbitrate as in IDLE: if any req go ACCESS with new grant, else IDLE.
- Arbitration: video fixed priority when both request.
- Requester may drop req in cycle after ack; req still high after ack is a new request.
- vid port is read-only; mem_we never set for video grants.
- mem_a/mem_din hold last value when idle; only mem_ce/mem_we are cleared.

## Timing
- Grant at edge E0 (req seen high) -> ack high cycle E0..E1, mem_ce high same cycle.
- RAM access at E1; read data captured and valid pulsed at E2; read latency 2 edges from grant.
- Peak throughput: one access per 2 cycles, back-to-back grants in RESP.
- Reset values: all outputs 0; state IDLE; fairness pointer = video.
- Reset mid-operation: access abandoned, no ack/valid emitted after reset; a write may already have committed if E1 preceded reset.
- Simultaneous req in same cycle: one ack only; loser keeps req held and is granted at next arbitration point (no loss).

## Configuration
- ZX_ARB_FAIR_EN defined: on contention, winner is the port that did not win the previous contended grant (pointer toggles only on contended grants; uncontended grants leave it unchanged). Bounds CPU wait to one video access.
- Undefined: strict video priority; CPU may starve while vid_req held.

## Structure
- Shared package zx_mem_pkg: state enum (IDLE/ACCESS/RESP), owner enum (OWN_CPU/OWN_VID), AW/DW defaults.
- One sub-module zx_arb_prio: combinational winner select from cpu_req, vid_req, fairness pointer; fairness pointer register stays in top level.

## Test plan
- CPU write 0x0123<-0xA5, then read 0x0123 -> cpu_ack one cycle each; cpu_valid 2 edges after read grant with cpu_dout=0xA5; no valid for write.
- Video read 0x0040 with RAM preloaded 0x3C -> vid_ack at E0, vid_valid at E2, vid_dout=0x3C, mem_we never 1.
- Both req same cycle, strict mode -> vid_ack first, cpu_ack at next RESP (2 cycles later); CPU data correct.
- vid_req held continuously, cpu_req held: strict -> no cpu_ack over 20 cycles; ZX_ARB_FAIR_EN -> grants alternate VID, CPU, VID, CPU.
- Reset asserted during ACCESS of a CPU read -> all outputs 0 immediately, no cpu_valid afterwards, state IDLE; next request serviced normally.
- Back-to-back CPU reads 0x0000..0x0003 -> grants every 2 cycles, four valid pulses with matching data, in order.
